// File: rtl/wb_dsp_pkg.sv
// Encodings shared by the DSP-bus Wishbone master and slave.
package wb_dsp_pkg;
  localparam int ADR_LSB   = 2;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'h0,
    SLV_WAIT = 2'h1,
    SLV_RESP = 2'h2
  } slv_state_t;

  typedef enum logic [1:0] {
    MST_IDLE     = 2'h0,
    MST_WAIT_ACK = 2'h1,
    MST_ERROR    = 2'h3
  } mst_state_t;
endpackage

// File: rtl/wb_slave_regfile.sv
// Register bank with byte-lane writes, read mux (last index = status_i) and write pulses.
// Writes land on the wr_en edge; reg_wr_o is registered, rd_dat is combinational.
module wb_slave_regfile
  import wb_dsp_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NUM_REGS = 8,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic                   wr_en,
  input  logic [IW-1:0]          idx,
  input  logic [DW-1:0]          wr_dat,
  input  logic [NUM_LANES-1:0]   wr_sel,
  input  logic [DW-1:0]          status_i,
  output logic [DW-1:0]          rd_dat,
  output logic [NUM_REGS*DW-1:0] regs_o,
  output logic [NUM_REGS-1:0]    reg_wr_o
);
  localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_REGS - 1);

  logic [DW-1:0] regs [NUM_REGS];

  // The status slot is never written, so it simply holds its reset value.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= '0;
      if (wr_en && idx != STATUS_IDX) begin
        reg_wr_o[idx] <= 1'b1;
        for (int b = 0; b < NUM_LANES; b++)
          if (wr_sel[b]) regs[idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_dat = (idx == STATUS_IDX) ? status_i : regs[idx];
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[k*DW +: DW] = regs[k];
  end
endmodule

// File: rtl/wb_slave_interface.sv
// Wishbone classic slave over a register bank: termination WAIT_STATES+1 cycles after the sample edge,
// priority rty > err > ack; the master holds cyc/stb until terminated, dropping cyc in WAIT aborts.
module wb_slave_interface
  import wb_dsp_pkg::*;
#(
  parameter int          dw          = 32,
  parameter int          aw          = 32,
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [aw-1:0]          wb_adr_i,
  input  logic [dw-1:0]          wb_dat_i,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic [dw-1:0]          wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  input  logic                   busy_i,
  input  logic [dw-1:0]          status_i,
  output logic [NUM_REGS*dw-1:0] regs_o,
  output logic [NUM_REGS-1:0]    reg_wr_o
);
  localparam int            IW      = $clog2(NUM_REGS);
  localparam logic [aw-1:0] BASE    = aw'(BASE_ADDR);
  localparam logic [aw-1:0] SPAN    = aw'(NUM_REGS * 4);
  localparam logic [3:0]    WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef struct packed {
    logic [aw-1:0]        adr;
    logic [dw-1:0]        dat;
    logic [NUM_LANES-1:0] sel;
    logic                 we;
  } req_t;

  slv_state_t    state;
  logic [3:0]    wait_cnt;
  req_t          lat_req, cur_req;
  logic [aw-1:0] offset;
  logic          borrow, hit, req, resp_go, wr_en;
  logic [IW-1:0] idx;
  logic [dw-1:0] rd_dat;

  assign req = wb_cyc_i & wb_stb_i;

  // With no wait states the response is decided on the sampling edge, straight from the bus.
  always_comb begin
    cur_req = lat_req;
    if (state == SLV_IDLE)
      cur_req = '{adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i, we: wb_we_i};
  end

  assign {borrow, offset} = {1'b0, cur_req.adr} - {1'b0, BASE};
  assign hit = !borrow && (offset < SPAN);
  assign idx = offset[ADR_LSB +: IW];

  assign resp_go = ((state == SLV_IDLE) && req && (WAIT_STATES == 0)) ||
                   ((state == SLV_WAIT) && wb_cyc_i && (wait_cnt == 4'd0));
  assign wr_en   = resp_go && !busy_i && hit && cur_req.we;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= SLV_IDLE;
      wait_cnt <= 4'd0;
      lat_req  <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
      case (state)
        SLV_IDLE: if (req) begin
          lat_req  <= cur_req;
          wait_cnt <= WS_LOAD;
          state    <= (WAIT_STATES == 0) ? SLV_RESP : SLV_WAIT;
        end
        SLV_WAIT: begin
          if (!wb_cyc_i)               state    <= SLV_IDLE;
          else if (wait_cnt == 4'd0)   state    <= SLV_RESP;
          else                         wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= SLV_IDLE;
      endcase
      if (resp_go) begin
        if (busy_i)      wb_rty_o <= 1'b1;
        else if (!hit)   wb_err_o <= 1'b1;
        else begin
          wb_ack_o <= 1'b1;
          if (!cur_req.we) wb_dat_o <= rd_dat;
        end
      end
    end
  end

  wb_slave_regfile #(
    .DW       (dw),
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_regfile (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wr_en    (wr_en),
    .idx      (idx),
    .wr_dat   (cur_req.dat),
    .wr_sel   (cur_req.sel),
    .status_i (status_i),
    .rd_dat   (rd_dat),
    .regs_o   (regs_o),
    .reg_wr_o (reg_wr_o)
  );
endmodule

// File: tb/tb_wb_slave_interface.sv
// Bench for wb_slave_interface: one instance with no wait states, one with three.
module tb_wb_slave_interface;
  localparam int NR = 8;
  localparam logic [2:0] T_ACK = 3'b100, T_ERR = 3'b010, T_RTY = 3'b001;

  typedef struct packed {
    logic [2:0]    term;
    logic [31:0]   dat;
    logic [NR-1:0] wr;
  } exp_t;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b0;
  always #5 wb_clk = ~wb_clk;

  logic [31:0]      adr, wdat, status;
  logic [3:0]       sel;
  logic             we, busy, cyc0, stb0, cyc3, stb3;
  logic [31:0]      dat0, dat3;
  logic             ack0, err0, rty0, ack3, err3, rty3;
  logic [NR*32-1:0] regs0, regs3;
  logic [NR-1:0]    wr0, wr3;

  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  wb_slave_interface #(.NUM_REGS(NR), .WAIT_STATES(0)) dut0 (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_dat_o(dat0), .wb_ack_o(ack0),
    .wb_err_o(err0), .wb_rty_o(rty0), .busy_i(busy), .status_i(status),
    .regs_o(regs0), .reg_wr_o(wr0));

  wb_slave_interface #(.NUM_REGS(NR), .WAIT_STATES(3)) dut3 (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_dat_o(dat3), .wb_ack_o(ack3),
    .wb_err_o(err3), .wb_rty_o(rty3), .busy_i(busy), .status_i(status),
    .regs_o(regs3), .reg_wr_o(wr3));

  // Scoreboards: every termination must match the oldest pushed expectation.
  always @(negedge wb_clk) begin
    if (!wb_rst && (ack0 | err0 | rty0)) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL dut0_unexpected_term got term=%b dat=%h", {ack0, err0, rty0}, dat0);
      end else begin
        e0 = q0.pop_front();
        if ({ack0, err0, rty0, dat0, wr0} !== {e0.term, e0.dat, e0.wr}) begin
          failures++;
          $display("FAIL dut0_response got term=%b dat=%h wr=%h want term=%b dat=%h wr=%h",
                   {ack0, err0, rty0}, dat0, wr0, e0.term, e0.dat, e0.wr);
        end
      end
    end else if (!wb_rst && wr0 !== '0) begin
      checks++; failures++;
      $display("FAIL dut0_stray_reg_wr got=%h want=00", wr0);
    end
  end

  always @(negedge wb_clk) begin
    if (!wb_rst && (ack3 | err3 | rty3)) begin
      checks++;
      if (q3.size() == 0) begin
        failures++;
        $display("FAIL dut3_unexpected_term got term=%b dat=%h", {ack3, err3, rty3}, dat3);
      end else begin
        e3 = q3.pop_front();
        if ({ack3, err3, rty3, dat3, wr3} !== {e3.term, e3.dat, e3.wr}) begin
          failures++;
          $display("FAIL dut3_response got term=%b dat=%h wr=%h want term=%b dat=%h wr=%h",
                   {ack3, err3, rty3}, dat3, wr3, e3.term, e3.dat, e3.wr);
        end
      end
    end else if (!wb_rst && wr3 !== '0) begin
      checks++; failures++;
      $display("FAIL dut3_stray_reg_wr got=%h want=00", wr3);
    end
  end

  // Starts at a falling edge, returns at the falling edge where a termination is visible.
  task automatic xfer(input bit d3, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w, output int lat);
    adr = a; wdat = d; sel = s; we = w;
    if (d3) begin cyc3 = 1'b1; stb3 = 1'b1; end
    else    begin cyc0 = 1'b1; stb0 = 1'b1; end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge wb_clk);
      if (d3 ? (ack3 | err3 | rty3) : (ack0 | err0 | rty0)) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic bus_idle();
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    @(negedge wb_clk);
  endtask

  task automatic test_reset();
    #1 wb_rst = 1'b1;
    #1;
    checks++;
    if ({ack0, err0, rty0, ack3, err3, rty3} !== 6'b0) begin
      failures++; $display("FAIL reset_term got=%b want=000000", {ack0, err0, rty0, ack3, err3, rty3});
    end
    checks++;
    if ({dat0, dat3} !== 64'h0) begin
      failures++; $display("FAIL reset_dat got=%h/%h want=0", dat0, dat3);
    end
    checks++;
    if ({regs0, regs3} !== '0) begin
      failures++; $display("FAIL reset_regs got=%h want=0", regs0);
    end
    checks++;
    if ({wr0, wr3} !== '0) begin
      failures++; $display("FAIL reset_reg_wr got=%h/%h want=0", wr0, wr3);
    end
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
  endtask

  task automatic test_write_read();
    int lat;
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h02});
    xfer(1'b0, 32'h4, 32'hDEADBEEF, 4'hF, 1'b1, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL write_latency got=%0d want=1", lat); end
    checks++;
    if (regs0[63:32] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL write_reg1 got=%h want=deadbeef", regs0[63:32]);
    end
    bus_idle();
    q0.push_back(exp_t'{T_ACK, 32'hDEADBEEF, 8'h00});
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL read_latency got=%0d want=1", lat); end
    bus_idle();
  endtask

  task automatic test_byte_lanes();
    int lat;
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h01});
    xfer(1'b0, 32'h0, 32'h11223344, 4'hF, 1'b1, lat); bus_idle();
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h01});
    xfer(1'b0, 32'h0, 32'hAABBCCDD, 4'b0101, 1'b1, lat); bus_idle();
    checks++;
    if (regs0[31:0] !== 32'h11BB33DD) begin
      failures++; $display("FAIL byte_lanes_reg0 got=%h want=11bb33dd", regs0[31:0]);
    end
    // Low address bits are ignored.
    q0.push_back(exp_t'{T_ACK, 32'h11BB33DD, 8'h00});
    xfer(1'b0, 32'h3, 32'h0, 4'hF, 1'b0, lat); bus_idle();
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h02});
    xfer(1'b0, 32'h4, 32'h12345678, 4'h0, 1'b1, lat); bus_idle();
    checks++;
    if (regs0[63:32] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL sel_zero_reg1 got=%h want=deadbeef", regs0[63:32]);
    end
  endtask

  task automatic test_status();
    int lat;
    status = 32'hCAFE0001;
    q0.push_back(exp_t'{T_ACK, 32'hCAFE0001, 8'h00});
    xfer(1'b0, 32'h1C, 32'h0, 4'hF, 1'b0, lat); bus_idle();
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h00});
    xfer(1'b0, 32'h1C, 32'hFFFFFFFF, 4'hF, 1'b1, lat); bus_idle();
    checks++;
    if (regs0[255:224] !== 32'h0) begin
      failures++; $display("FAIL status_write_reg7 got=%h want=0", regs0[255:224]);
    end
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h40});
    xfer(1'b0, 32'h18, 32'h600D600D, 4'hF, 1'b1, lat); bus_idle();
    q0.push_back(exp_t'{T_ACK, 32'h600D600D, 8'h00});
    xfer(1'b0, 32'h18, 32'h0, 4'hF, 1'b0, lat); bus_idle();
  endtask

  task automatic test_miss();
    int lat;
    logic [NR*32-1:0] snap;
    snap = '0;
    snap[31:0] = 32'h11BB33DD;
    snap[63:32] = 32'hDEADBEEF;
    snap[223:192] = 32'h600D600D;
    q0.push_back(exp_t'{T_ERR, 32'h0, 8'h00});
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat); bus_idle();
    q0.push_back(exp_t'{T_ERR, 32'h0, 8'h00});
    xfer(1'b0, 32'h20, 32'h55555555, 4'hF, 1'b1, lat); bus_idle();
    checks++;
    if (regs0 !== snap) begin failures++; $display("FAIL miss_regs got=%h want=%h", regs0, snap); end
  endtask

  task automatic test_busy();
    int lat;
    busy = 1'b1;
    q0.push_back(exp_t'{T_RTY, 32'h0, 8'h00});
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, lat); bus_idle();
    q0.push_back(exp_t'{T_RTY, 32'h0, 8'h00});
    xfer(1'b0, 32'h18, 32'h0, 4'hF, 1'b1, lat); bus_idle();
    q0.push_back(exp_t'{T_RTY, 32'h0, 8'h00});
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat); bus_idle();
    busy = 1'b0;
    checks++;
    if (regs0[223:192] !== 32'h600D600D) begin
      failures++; $display("FAIL busy_reg6 got=%h want=600d600d", regs0[223:192]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h04});
    q0.push_back(exp_t'{T_ACK, 32'h0, 8'h08});
    xfer(1'b0, 32'h8, 32'hA1A1A1A1, 4'hF, 1'b1, lat);
    // stb stays high: the RESP cycle must not sample the next request.
    xfer(1'b0, 32'hC, 32'hB2B2B2B2, 4'hF, 1'b1, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL b2b_latency got=%0d want=2", lat); end
    bus_idle();
    checks++;
    if (regs0[127:64] !== 64'hB2B2B2B2_A1A1A1A1) begin
      failures++; $display("FAIL b2b_regs got=%h want=b2b2b2b2a1a1a1a1", regs0[127:64]);
    end
  endtask

  task automatic test_wait_states();
    int lat;
    bit seen;
    q3.push_back(exp_t'{T_ACK, 32'h0, 8'h04});
    xfer(1'b1, 32'h8, 32'h0BADF00D, 4'hF, 1'b1, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ws_write_latency got=%0d want=4", lat); end
    bus_idle();
    q3.push_back(exp_t'{T_ACK, 32'h0BADF00D, 8'h00});
    xfer(1'b1, 32'h8, 32'h0, 4'hF, 1'b0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ws_read_latency got=%0d want=4", lat); end
    bus_idle();
    adr = 32'h8; wdat = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; cyc3 = 1'b1; stb3 = 1'b1;
    repeat (2) @(negedge wb_clk);
    cyc3 = 1'b0; stb3 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge wb_clk);
      if (ack3 | err3 | rty3) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_term got=1 want=0"); end
    checks++;
    if (regs3[95:64] !== 32'h0BADF00D) begin
      failures++; $display("FAIL abort_reg2 got=%h want=0badf00d", regs3[95:64]);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    bit seen;
    adr = 32'h8; wdat = 32'h55AA55AA; sel = 4'hF; we = 1'b1; cyc3 = 1'b1; stb3 = 1'b1;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b1;
    #1;
    checks++;
    if (regs3 !== '0) begin failures++; $display("FAIL midop_regs got=%h want=0", regs3); end
    checks++;
    if ({ack3, err3, rty3, dat3, wr3} !== '0) begin
      failures++; $display("FAIL midop_outputs got=%b/%h/%h want=0", {ack3, err3, rty3}, dat3, wr3);
    end
    cyc3 = 1'b0; stb3 = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge wb_clk);
      if (ack3 | err3 | rty3) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=1 want=0"); end
    q3.push_back(exp_t'{T_ACK, 32'h0, 8'h00});
    xfer(1'b1, 32'h8, 32'h0, 4'hF, 1'b0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL post_reset_latency got=%0d want=4", lat); end
    bus_idle();
  endtask

  initial begin
    adr = '0; wdat = '0; sel = '0; we = 1'b0; busy = 1'b0; status = '0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_status();
    test_miss();
    test_busy();
    test_back_to_back();
    test_wait_states();
    test_reset_midop();
    repeat (2) @(negedge wb_clk);
    checks++;
    if (q0.size() != 0 || q3.size() != 0) begin
      failures++; $display("FAIL pending_expectations got=%0d/%0d want=0/0", q0.size(), q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_slave_interface.md
Name: wb_slave_interface

Overview:
- Wishbone classic-cycle slave (responder) exposing a bank of NUM_REGS 32-bit registers to the bus.
- Sits opposite the team's Wishbone bus master on the DSP bus. Gives the DSP core its configuration registers, per-register write pulses and one read-only status word.
- Supports programmable wait states, byte-lane writes, err on address miss and rty when the core is busy.

Parameters:
- dw, 32, data width; only 32 supported (4 byte lanes)
- aw, 32, address width
- NUM_REGS, 8, number of registers (2..16); index NUM_REGS-1 is the read-only status word
- BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to NUM_REGS*4
- WAIT_STATES, 0, extra cycles inserted before the response (0..15)

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  reset; asynchronous, active-high
- wb_adr_i  in  aw  byte address
- wb_dat_i  in  dw  write data
- wb_sel_i  in  4  byte lane selects
- wb_we_i  in  1  1 = write
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_dat_o  out  dw  read data; valid only while wb_ack_o is high
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (address miss)
- wb_rty_o  out  1  retry termination (core busy)
- busy_i  in  1  core busy; requests sampled while high get rty
- status_i  in  dw  value returned for register NUM_REGS-1
- regs_o  out  NUM_REGS*dw  flattened register contents; reg k at [k*dw +: dw]
- reg_wr_o  out  NUM_REGS  one-cycle pulse, bit k set on the edge register k is written

Behaviour:
- Reset (async, wb_rst=1): state=IDLE, wait counter=0, all registers=0.
  - Outputs during reset: wb_dat_o=0, ack/err/rty=0, reg_wr_o=0.
- All outputs are registered; no combinational path from bus inputs to outputs.
- Decode:
  - hit = BASE_ADDR <= wb_adr_i < BASE_ADDR+NUM_REGS*4
  - idx = (wb_adr_i-BASE_ADDR)>>2
  - wb_adr_i[1:0] ignored
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Request = wb_cyc_i & wb_stb_i. Latch adr/we/sel/dat at the sampling edge.
  - If WAIT_STATES=0, go to RESP. Otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle; at 0, go to RESP.
  - If wb_cyc_i=0 in any WAIT cycle, abort to IDLE: no termination, no register change.
- Entry into RESP (the same edge that sets exactly one termination bit high for one cycle). Termination priority: rty > err > ack.
  - rty: busy_i=1 sampled on the entry edge.
  - err: address miss. wb_dat_o=0, no write.
  - ack, read: wb_dat_o = reg[idx], or status_i when idx=NUM_REGS-1 (sampled on that edge).
  - ack, write: for each lane b with sel[b]=1, reg[idx][8b+7:8b] <= dat[8b+7:8b]; reg_wr_o[idx]=1 for that cycle.
  - Write to NUM_REGS-1: acked, contents unchanged, no reg_wr_o pulse.
  - sel=0 write: acked, no byte changes, reg_wr_o still pulses.
- RESP: lasts exactly one cycle. Termination, wb_dat_o and reg_wr_o return to 0 on the next edge; state returns to IDLE.
- Latency: request first sampled at edge E gives termination high during cycle E+1+WAIT_STATES.
- Back-to-back: a new request is only sampled in IDLE. The earliest next sample is the edge after the RESP cycle, so there is no double response while the master is still deasserting stb.
- Reset mid-transaction: immediate return to reset values; a pending write is lost.

Decomposition:
- Shared package wb_dsp_pkg: FSM state encodings (IDLE=2'h0, WAIT=2'h1, RESP=2'h2), ADR_LSB=2, byte-lane count 4.
  - The package is shared with the bus master, whose encodings for IDLE/WAIT_ACK/ERROR are 0/1/3.
- One sub-module: wb_slave_regfile. Holds the register array with byte-lane write enables, the read mux including status_i, and generates reg_wr_o.
- The top level holds decode, wait counter, FSM and termination logic.

Test Plan:
- WAIT_STATES=0: write adr=0x4, dat=0xDEADBEEF, sel=4'hF.
  - Expect ack one cycle after stb, reg_wr_o=8'h02 pulse, regs_o[63:32]=0xDEADBEEF.
  - Then read 0x4 -> wb_dat_o=0xDEADBEEF with ack.
- Byte lanes: reg 0 = 0x11223344, then write 0xAABBCCDD with sel=4'b0101 -> read returns 0x11BB33DD.
- WAIT_STATES=3: read of 0x8 -> ack rises exactly 4 cycles after the first stb sample.
  - Drop cyc after 2 cycles on a second attempt -> no ack, reg unchanged.
- Address miss: read 0x20 (NUM_REGS=8) -> err one cycle, wb_dat_o=0, ack=0.
  - Write 0x20 -> err, regs unchanged, reg_wr_o=0.
- Status and busy:
  - status_i=0xCAFE0001, read 0x1C -> ack with 0xCAFE0001.
  - Write 0x1C -> ack, no change, no pulse.
  - busy_i=1 on any request -> rty only.
- Reset mid-op: assert wb_rst during WAIT after a pending write.
  - Expect outputs and regs cleared immediately (async), no ack.
  - After release, idle until the next stb.
